// File: rtl/bru_pkg.sv
// Shared types and defaults for the branch resolve unit: FSM encoding, widths,
// and the BTB tag-width helper.
package bru_pkg;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } bru_state_e;

    localparam int BRU_PC_W  = 32;
    localparam int BRU_IDX_W = 5;
    localparam int BRU_CNT_W = 32;

    // The two low PC bits are not stored because instructions are word aligned.
    function automatic int bru_tag_w(input int pc_w, input int idx_w);
        return pc_w - idx_w - 2;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the front end / EX stage and the branch resolve unit.
// The slave side is the resolve unit; the master side is the pipeline driving it.
interface branch_resolve_unit_if
    import bru_pkg::*;
#(
    parameter int PC_W  = BRU_PC_W,
    parameter int IDX_W = BRU_IDX_W,
    parameter int CNT_W = BRU_CNT_W
) ();

    localparam int TAG_W = bru_tag_w(PC_W, IDX_W);

    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic [PC_W-1:0]  if_pred_pc;
    logic             if_pred_taken;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_cond_taken;
    logic [PC_W-1:0]  ex_target;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [PC_W-1:0]  upd_target;
    logic             upd_correct;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    modport slave (
        input  if_valid, if_pc, if_pred_pc, if_pred_taken,
        input  stall_if_id, stall_id_ex,
        input  ex_is_branch, ex_is_jump, ex_cond_taken, ex_target,
        output upd_valid, upd_idx, upd_tag, upd_target, upd_correct,
        output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
        output stat_branches, stat_mispred
    );

    modport master (
        output if_valid, if_pc, if_pred_pc, if_pred_taken,
        output stall_if_id, stall_id_ex,
        output ex_is_branch, ex_is_jump, ex_cond_taken, ex_target,
        input  upd_valid, upd_idx, upd_tag, upd_target, upd_correct,
        input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
        input  stat_branches, stat_mispred
    );

endinterface

// File: rtl/pred_meta_stage.sv
// One pipeline slot of prediction metadata {valid, pc, pred_pc, pred_taken}.
// Flush beats load so a squash always wins over a held or incoming entry.
module pred_meta_stage
    import bru_pkg::*;
#(
    parameter int PC_W = BRU_PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pred_pc_i,
    input  logic            pred_taken_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pred_pc_o,
    output logic            pred_taken_o
);

    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pred_pc_q;
    logic            pred_taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            pred_pc_q    <= '0;
            pred_taken_q <= 1'b0;
        end else if (flush_i) begin
            valid_q      <= 1'b0;
        end else if (load_i) begin
            valid_q      <= valid_i;
            pc_q         <= pc_i;
            pred_pc_q    <= pred_pc_i;
            pred_taken_q <= pred_taken_i;
        end
    end

    assign valid_o      = valid_q;
    assign pc_o         = pc_q;
    assign pred_pc_o    = pred_pc_q;
    assign pred_taken_o = pred_taken_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: compares the carried prediction with the real next PC,
// emits predictor update, redirect and flushes one cycle later, and counts branches.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W        = BRU_PC_W,
    parameter int IDX_W       = BRU_IDX_W,
    parameter int CNT_W       = BRU_CNT_W,
    parameter int RECOVER_CYC = 2
) (
    input  logic                clk,
    input  logic                reset,
    branch_resolve_unit_if.slave bus
);

    localparam int TAG_W = bru_tag_w(PC_W, IDX_W);
    localparam int RC_W  = $clog2(RECOVER_CYC + 1);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic            id_valid, ex_valid;
    logic [PC_W-1:0] id_pc, id_pred_pc, ex_pc, ex_pred_pc;
    logic            id_pred_taken, ex_pred_taken;

    bru_state_e      state_q, state_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic [TAG_W-1:0] upd_tag_q, upd_tag_d;
    logic [PC_W-1:0]  upd_target_q, upd_target_d;
    logic             upd_correct_q, upd_correct_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_if_id_q, flush_id_ex_q;
    logic [CNT_W-1:0] stat_br_q, stat_br_d;
    logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

    logic            resolve, correct, mispred;
    logic [PC_W-1:0] actual;

    // The direction bit rides along for the predictor but the resolver only needs the PC.
    logic unused_ex_pred_taken;
    assign unused_ex_pred_taken = ex_pred_taken;

    pred_meta_stage #(.PC_W(PC_W)) u_id (
        .clk          (clk),
        .rst_n        (reset),
        .load_i       (!bus.stall_if_id),
        .flush_i      (flush_if_id_q),
        .valid_i      (bus.if_valid),
        .pc_i         (bus.if_pc),
        .pred_pc_i    (bus.if_pred_pc),
        .pred_taken_i (bus.if_pred_taken),
        .valid_o      (id_valid),
        .pc_o         (id_pc),
        .pred_pc_o    (id_pred_pc),
        .pred_taken_o (id_pred_taken)
    );

    // A stalled ID hands EX a bubble rather than a duplicate of the held entry.
    pred_meta_stage #(.PC_W(PC_W)) u_ex (
        .clk          (clk),
        .rst_n        (reset),
        .load_i       (!bus.stall_id_ex),
        .flush_i      (flush_id_ex_q),
        .valid_i      (id_valid & ~bus.stall_if_id),
        .pc_i         (id_pc),
        .pred_pc_i    (id_pred_pc),
        .pred_taken_i (id_pred_taken),
        .valid_o      (ex_valid),
        .pc_o         (ex_pc),
        .pred_pc_o    (ex_pred_pc),
        .pred_taken_o (ex_pred_taken)
    );

    assign resolve = ex_valid && (bus.ex_is_branch || bus.ex_is_jump)
                     && (state_q == ST_NORMAL) && !bus.stall_id_ex;
    assign actual  = (bus.ex_is_jump || bus.ex_cond_taken) ? bus.ex_target
                                                           : ex_pc + PC_W'(4);
    assign correct = (actual == ex_pred_pc);
    assign mispred = resolve && !correct;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (mispred) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = RC_LOAD;
                end
            end
            ST_RECOVER: begin
                if (rcnt_q <= RC_W'(1)) begin
                    state_d = ST_NORMAL;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q - RC_W'(1);
                end
            end
            default: begin
                state_d = ST_NORMAL;
                rcnt_d  = '0;
            end
        endcase

        upd_valid_d   = resolve;
        upd_idx_d     = resolve ? ex_pc[IDX_W+1:2] : '0;
        upd_tag_d     = resolve ? ex_pc[PC_W-1:IDX_W+2] : '0;
        upd_target_d  = resolve ? actual : '0;
        upd_correct_d = resolve && correct;
        redirect_d    = mispred;
        redirect_pc_d = mispred ? actual : '0;
        stat_br_d     = resolve ? sat_inc(stat_br_q) : stat_br_q;
        stat_mp_d     = mispred ? sat_inc(stat_mp_q) : stat_mp_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_NORMAL;
            rcnt_q        <= '0;
            upd_valid_q   <= 1'b0;
            upd_idx_q     <= '0;
            upd_tag_q     <= '0;
            upd_target_q  <= '0;
            upd_correct_q <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            stat_br_q     <= '0;
            stat_mp_q     <= '0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            upd_valid_q   <= upd_valid_d;
            upd_idx_q     <= upd_idx_d;
            upd_tag_q     <= upd_tag_d;
            upd_target_q  <= upd_target_d;
            upd_correct_q <= upd_correct_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_if_id_q <= redirect_d;
            flush_id_ex_q <= redirect_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_idx        = upd_idx_q;
    assign bus.upd_tag        = upd_tag_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.upd_correct    = upd_correct_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if_id    = flush_if_id_q;
    assign bus.flush_id_ex    = flush_id_ex_q;
    assign bus.stat_branches  = stat_br_q;
    assign bus.stat_mispred   = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level model of the pipeline.
module tb_branch_resolve_unit;

    localparam int PC_W  = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;
    localparam int RCYC  = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pred;
    } meta_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    meta_t       m_id, m_ex;
    int          m_rec, m_br, m_mp;
    logic        e_upd_valid, e_correct, e_redir;
    logic [31:0] e_idx, e_tag, e_target, e_rpc;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .RECOVER_CYC(RCYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_id = '0; m_ex = '0;
        m_rec = 0; m_br = 0; m_mp = 0;
        e_upd_valid = 0; e_correct = 0; e_redir = 0;
        e_idx = 0; e_tag = 0; e_target = 0; e_rpc = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        logic        res, cor, fl;
        logic [31:0] act;
        meta_t       nid, nex;
        fl  = e_redir;
        res = m_ex.v && (bus.ex_is_branch || bus.ex_is_jump) && (m_rec == 0) && !bus.stall_id_ex;
        if (bus.ex_is_jump)         act = bus.ex_target;
        else if (bus.ex_cond_taken) act = bus.ex_target;
        else                        act = m_ex.pc + 32'd4;
        cor = (act == m_ex.pred);
        e_upd_valid = res;
        e_idx       = res ? (m_ex.pc / 4) % (1 << IDX_W) : 0;
        e_tag       = res ? m_ex.pc / (4 << IDX_W) : 0;
        e_target    = res ? act : 0;
        e_correct   = res && cor;
        e_redir     = res && !cor;
        e_rpc       = e_redir ? act : 0;
        if (res)     m_br = (m_br < SAT) ? m_br + 1 : SAT;
        if (e_redir) m_mp = (m_mp < SAT) ? m_mp + 1 : SAT;
        if (e_redir)       m_rec = RCYC;
        else if (m_rec > 0) m_rec--;
        nid = m_id;
        nex = m_ex;
        if (!bus.stall_id_ex) nex = bus.stall_if_id ? meta_t'(0) : m_id;
        if (!bus.stall_if_id) nid = {bus.if_valid, bus.if_pc, bus.if_pred_pc};
        if (fl) begin
            nid.v = 1'b0;
            nex.v = 1'b0;
        end
        m_id = nid;
        m_ex = nex;
    endtask

    task automatic check_all();
        chk("upd_valid",      bus.upd_valid,      e_upd_valid);
        chk("upd_idx",        bus.upd_idx,        e_idx);
        chk("upd_tag",        bus.upd_tag,        e_tag);
        chk("upd_target",     bus.upd_target,     e_target);
        chk("upd_correct",    bus.upd_correct,    e_correct);
        chk("redirect_valid", bus.redirect_valid, e_redir);
        chk("redirect_pc",    bus.redirect_pc,    e_rpc);
        chk("flush_if_id",    bus.flush_if_id,    e_redir);
        chk("flush_id_ex",    bus.flush_id_ex,    e_redir);
        chk("stat_branches",  bus.stat_branches,  m_br);
        chk("stat_mispred",   bus.stat_mispred,   m_mp);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_ex();
        bus.ex_is_branch = 0; bus.ex_is_jump = 0; bus.ex_cond_taken = 0; bus.ex_target = 0;
    endtask

    task automatic clr_all();
        bus.if_valid = 0; bus.if_pc = 0; bus.if_pred_pc = 0; bus.if_pred_taken = 0;
        bus.stall_if_id = 0; bus.stall_id_ex = 0;
        clr_ex();
    endtask

    task automatic idle(input int n);
        clr_all();
        for (int i = 0; i < n; i++) step();
    endtask

    // Fetch one instruction, let it reach EX, and present its outcome there.
    task automatic issue(input logic [31:0] pc, input logic [31:0] pred,
                         input logic br, input logic jmp, input logic tk,
                         input logic [31:0] tgt);
        clr_all();
        bus.if_valid = 1; bus.if_pc = pc; bus.if_pred_pc = pred; bus.if_pred_taken = (pred != pc + 4);
        step();
        clr_all();
        step();
        bus.ex_is_branch = br; bus.ex_is_jump = jmp; bus.ex_cond_taken = tk; bus.ex_target = tgt;
        step();
        clr_ex();
    endtask

    initial begin
        reset = 1'b0;
        clr_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_upd_valid", bus.upd_valid, 0);
        reset = 1'b1;

        // BEQ not taken, predicted fall-through
        issue(32'h40, 32'h44, 1, 0, 0, 32'h80);
        chk("t1_upd_valid", bus.upd_valid, 1);
        chk("t1_correct", bus.upd_correct, 1);
        chk("t1_idx", bus.upd_idx, 5'h10);
        chk("t1_redirect", bus.redirect_valid, 0);
        chk("t1_branches", bus.stat_branches, 1);

        // BNE taken but predicted fall-through
        issue(32'h80, 32'h84, 1, 0, 1, 32'h100);
        chk("t2_redirect", bus.redirect_valid, 1);
        chk("t2_redirect_pc", bus.redirect_pc, 32'h100);
        chk("t2_flush_if_id", bus.flush_if_id, 1);
        chk("t2_flush_id_ex", bus.flush_id_ex, 1);
        chk("t2_target", bus.upd_target, 32'h100);
        chk("t2_mispred", bus.stat_mispred, 1);
        idle(2);

        // JAL correct, then same JAL mispredicted
        issue(32'h20, 32'h60, 0, 1, 0, 32'h60);
        chk("t3_correct", bus.upd_correct, 1);
        chk("t3_tag", bus.upd_tag, 0);
        issue(32'h20, 32'h24, 0, 1, 0, 32'h60);
        chk("t3_redirect", bus.redirect_valid, 1);
        chk("t3_redirect_pc", bus.redirect_pc, 32'h60);
        idle(2);

        // Mispredict with a younger branch right behind it: the younger one is ignored
        clr_all();
        bus.if_valid = 1; bus.if_pc = 32'h100; bus.if_pred_pc = 32'h104;
        step();
        bus.if_pc = 32'h104; bus.if_pred_pc = 32'h108;
        step();
        clr_all();
        bus.ex_is_branch = 1; bus.ex_cond_taken = 1; bus.ex_target = 32'h200;
        step();
        chk("t4_redirect_pc", bus.redirect_pc, 32'h200);
        bus.ex_target = 32'h300;
        step();
        chk("t4_recover_upd", bus.upd_valid, 0);
        chk("t4_recover_redir", bus.redirect_valid, 0);
        step();
        chk("t4_recover_upd2", bus.upd_valid, 0);
        idle(1);
        issue(32'h140, 32'h144, 1, 0, 0, 32'h0);
        chk("t4_after_upd", bus.upd_valid, 1);
        chk("t4_after_correct", bus.upd_correct, 1);

        // Mispredicting branch held in EX by a 3-cycle stall
        clr_all();
        bus.if_valid = 1; bus.if_pc = 32'h180; bus.if_pred_pc = 32'h184;
        step();
        clr_all();
        step();
        bus.ex_is_branch = 1; bus.ex_cond_taken = 1; bus.ex_target = 32'h1c0;
        bus.stall_id_ex = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_stalled_upd", bus.upd_valid, 0);
        end
        bus.stall_id_ex = 0;
        step();
        chk("t5_redirect", bus.redirect_valid, 1);
        chk("t5_redirect_pc", bus.redirect_pc, 32'h1c0);
        chk("t5_branches", bus.stat_branches, 7);
        chk("t5_mispred", bus.stat_mispred, 4);
        clr_ex();
        step();
        chk("t5_single", bus.redirect_valid, 0);
        idle(2);

        // Random traffic; also drives both counters into saturation
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] pc;
            pc = 32'($urandom_range(0, 1023)) << 2;
            bus.if_valid      = ($urandom_range(0, 3) != 0);
            bus.if_pc         = pc;
            bus.if_pred_pc    = $urandom_range(0, 1) ? pc + 32'd4 : (32'($urandom_range(0, 1023)) << 2);
            bus.if_pred_taken = $urandom_range(0, 1);
            bus.stall_if_id   = ($urandom_range(0, 7) == 0);
            bus.stall_id_ex   = ($urandom_range(0, 7) == 0);
            bus.ex_is_branch  = $urandom_range(0, 1);
            bus.ex_is_jump    = ($urandom_range(0, 3) == 0);
            bus.ex_cond_taken = $urandom_range(0, 1);
            bus.ex_target     = $urandom_range(0, 1) ? m_ex.pred : (32'($urandom_range(0, 1023)) << 2);
            step();
        end
        idle(3);
        chk("sat_branches", bus.stat_branches, SAT);
        chk("sat_mispred", bus.stat_mispred, SAT);

        // Mispredict at saturation, then async reset while recovering
        issue(32'h200, 32'h204, 1, 0, 1, 32'h280);
        chk("t6_redirect", bus.redirect_valid, 1);
        chk("t6_sat_branches", bus.stat_branches, SAT);
        chk("t6_sat_mispred", bus.stat_mispred, SAT);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_redirect", bus.redirect_valid, 0);
        chk("t6_rst_branches", bus.stat_branches, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(32'h240, 32'h300, 1, 0, 1, 32'h300);
        chk("t6_post_upd", bus.upd_valid, 1);
        chk("t6_post_correct", bus.upd_correct, 1);
        chk("t6_post_branches", bus.stat_branches, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
